// File: rtl/hamming_pkg.sv
// Shared types and elaboration-time helpers for the SECDED decoder.
package hamming_pkg;

    typedef enum logic [1:0] {ERR_NONE, ERR_CORR, ERR_UNCORR} err_class_e;

    // Smallest p with 2^p >= data_w + p + 1.
    function automatic int calc_par_w(input int data_w);
        int p;
        p = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << p) < data_w + p + 1) p = p + 1;
        end
        return p;
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Hamming position of data bit idx: the idx-th non-power-of-two position from 3 up.
    function automatic int data_pos(input int idx);
        int n;
        int pos;
        n   = 0;
        pos = 0;
        for (int p = 3; p < 2 * idx + 8; p++) begin
            if (!is_pow2(p)) begin
                if (n == idx) pos = p;
                n = n + 1;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome and overall parity of a received codeword.
module hamming_syndrome #(
    parameter int unsigned CW_W  = 8,
    parameter int unsigned PAR_W = $clog2(CW_W)
) (
    input  logic [CW_W-1:0]  codeword,
    output logic [PAR_W-1:0] syndrome,
    output logic             parity_err
);

    // Syndrome bit k folds in every position whose index has bit k set.
    always_comb begin
        syndrome = '0;
        for (int i = 1; i < int'(CW_W); i++) begin
            for (int k = 0; k < int'(PAR_W); k++) begin
                if (((i >> k) & 1) != 0) syndrome[k] = syndrome[k] ^ codeword[i];
            end
        end
    end

    assign parity_err = ^codeword;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage SECDED decoder with valid/ready backpressure and saturating error counters.
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter bit CORRECT_EN = 1'b1,
    parameter int CNT_W      = 16,
    localparam int PAR_W     = calc_par_w(DATA_W),
    localparam int CW_W      = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_codeword,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic              out_err_corr,
    output logic              out_err_uncorr,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count
);

    logic [PAR_W-1:0]  syn_d;
    logic              par_d;
    logic [DATA_W-1:0] in_data;

    // Stage 1 keeps only the data payload; the check bits are fully consumed by the syndrome.
    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [PAR_W-1:0]  s1_syn_q;
    logic              s1_par_q;

    logic              s2_valid_q;
    logic [DATA_W-1:0] s2_data_q;
    logic [PAR_W-1:0]  s2_syn_q;
    logic              s2_corr_q;
    logic              s2_uncorr_q;

    logic [CNT_W-1:0]  corr_cnt_q;
    logic [CNT_W-1:0]  uncorr_cnt_q;

    err_class_e        cls;
    logic              flip_en;
    logic [DATA_W-1:0] data_d;
    logic              s2_ready;

    hamming_syndrome #(
        .CW_W  (CW_W),
        .PAR_W (PAR_W)
    ) u_syndrome (
        .codeword   (in_codeword),
        .syndrome   (syn_d),
        .parity_err (par_d)
    );

    assign s2_ready = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;
    assign flip_en  = CORRECT_EN && (cls == ERR_CORR);

    for (genvar k = 0; k < DATA_W; k++) begin : g_data
        assign in_data[k] = in_codeword[data_pos(k)];
        // A syndrome of 0 (parity-bit error) never matches a data position, so no flip then.
        assign data_d[k]  = s1_data_q[k] ^ (flip_en && (int'(s1_syn_q) == data_pos(k)));
    end

    // Classify the stage-1 word from its syndrome and overall parity.
    always_comb begin
        cls = ERR_UNCORR;
        if (s1_syn_q == '0) begin
            cls = s1_par_q ? ERR_CORR : ERR_NONE;
        end else if (s1_par_q && (int'(s1_syn_q) <= CW_W - 1)) begin
            cls = ERR_CORR;
        end
    end

    // Pipeline registers: each stage loads when its successor is free or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_syn_q    <= '0;
            s1_par_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_syn_q    <= '0;
            s2_corr_q   <= 1'b0;
            s2_uncorr_q <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_data_q <= in_data;
                    s1_syn_q  <= syn_d;
                    s1_par_q  <= par_d;
                end
            end
            if (s2_ready) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q   <= data_d;
                    s2_syn_q    <= s1_syn_q;
                    s2_corr_q   <= (cls == ERR_CORR);
                    s2_uncorr_q <= (cls == ERR_UNCORR);
                end
            end
        end
    end

    // Saturating error counters, bumped on output transfers; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else if (s2_valid_q && out_ready) begin
            if (s2_corr_q && (corr_cnt_q != '1)) corr_cnt_q <= corr_cnt_q + CNT_W'(1);
            if (s2_uncorr_q && (uncorr_cnt_q != '1)) uncorr_cnt_q <= uncorr_cnt_q + CNT_W'(1);
        end
    end

    assign out_valid      = s2_valid_q;
    assign out_data       = s2_data_q;
    assign out_syndrome   = s2_syn_q;
    assign out_err_corr   = s2_corr_q;
    assign out_err_uncorr = s2_uncorr_q;
    assign corr_count     = corr_cnt_q;
    assign uncorr_count   = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed-vector bench for the SECDED decoder, plus random flips on wider instances.
module tb_hamming_secded_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, cnt_clear;
    logic [7:0]  cw4;
    logic [15:0] cw11;
    logic [31:0] cw26;

    // a: DATA_W=4 correcting; b: detect-only; c: 2-bit counters; d/e: wide instances.
    logic        ir_a, ov_a, oc_a, ou_a;
    logic [3:0]  od_a;
    logic [2:0]  os_a;
    logic [15:0] cc_a, uc_a;
    logic        ir_b, ov_b, oc_b, ou_b;
    logic [3:0]  od_b;
    logic [2:0]  os_b;
    logic [15:0] cc_b, uc_b;
    logic        ir_c, ov_c, oc_c, ou_c;
    logic [3:0]  od_c;
    logic [2:0]  os_c;
    logic [1:0]  cc_c, uc_c;
    logic        ir_d, ov_d, oc_d, ou_d;
    logic [10:0] od_d;
    logic [3:0]  os_d;
    logic [15:0] cc_d, uc_d;
    logic        ir_e, ov_e, oc_e, ou_e;
    logic [25:0] od_e;
    logic [4:0]  os_e;
    logic [15:0] cc_e, uc_e;

    hamming_secded_decoder #(.DATA_W(4), .CORRECT_EN(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .in_codeword(cw4),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_syndrome(os_a),
        .out_err_corr(oc_a), .out_err_uncorr(ou_a), .cnt_clear(cnt_clear),
        .corr_count(cc_a), .uncorr_count(uc_a));
    hamming_secded_decoder #(.DATA_W(4), .CORRECT_EN(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .in_codeword(cw4),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_syndrome(os_b),
        .out_err_corr(oc_b), .out_err_uncorr(ou_b), .cnt_clear(cnt_clear),
        .corr_count(cc_b), .uncorr_count(uc_b));
    hamming_secded_decoder #(.DATA_W(4), .CORRECT_EN(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c), .in_codeword(cw4),
        .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .out_syndrome(os_c),
        .out_err_corr(oc_c), .out_err_uncorr(ou_c), .cnt_clear(cnt_clear),
        .corr_count(cc_c), .uncorr_count(uc_c));
    hamming_secded_decoder #(.DATA_W(11), .CORRECT_EN(1'b1), .CNT_W(16)) dut_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_d), .in_codeword(cw11),
        .out_valid(ov_d), .out_ready(out_ready), .out_data(od_d), .out_syndrome(os_d),
        .out_err_corr(oc_d), .out_err_uncorr(ou_d), .cnt_clear(cnt_clear),
        .corr_count(cc_d), .uncorr_count(uc_d));
    hamming_secded_decoder #(.DATA_W(26), .CORRECT_EN(1'b1), .CNT_W(16)) dut_e (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_e), .in_codeword(cw26),
        .out_valid(ov_e), .out_ready(out_ready), .out_data(od_e), .out_syndrome(os_e),
        .out_err_corr(oc_e), .out_err_uncorr(ou_e), .cnt_clear(cnt_clear),
        .corr_count(cc_e), .uncorr_count(uc_e));

    typedef struct {
        logic [7:0] cw;
        logic [3:0] dc;     // expected data, correcting instance
        logic [3:0] dr;     // expected data, detect-only instance
        logic [2:0] syn;
        logic       corr;
        logic       uncorr;
    } vec_t;

    vec_t tbl[10];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit pw2(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    // Reference encoder: data into non-power-of-two positions, then check bits, then bit 0.
    function automatic logic [31:0] enc(input int dw, input int cww, input logic [31:0] d);
        logic [31:0] c;
        logic        x;
        int          k;
        c = '0;
        k = 0;
        for (int p = 1; p < cww; p++) begin
            if (!pw2(p) && k < dw) begin
                c[p] = d[k];
                k++;
            end
        end
        for (int b = 0; (1 << b) < cww; b++) begin
            x = 1'b0;
            for (int p = 1; p < cww; p++) if (((p >> b) & 1) == 1) x = x ^ c[p];
            c[1 << b] = x;
        end
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [31:0] ext(input int dw, input int cww, input logic [31:0] c);
        logic [31:0] d;
        int          k;
        d = '0;
        k = 0;
        for (int p = 1; p < cww; p++) begin
            if (!pw2(p) && k < dw) begin
                d[k] = c[p];
                k++;
            end
        end
        return d;
    endfunction

    // Random word with 0, 1 or 2 flipped bits and its expected decode.
    task automatic gen(input int dw, input int cww, output logic [31:0] cw,
                       output logic [31:0] dat, output logic [31:0] syn,
                       output logic corr, output logic uncorr);
        logic [31:0] d;
        int          nf, a, b;
        d  = $urandom & ((32'h1 << dw) - 32'h1);
        cw = enc(dw, cww, d);
        nf = int'($urandom_range(0, 2));
        a  = int'($urandom_range(0, cww - 1));
        b  = (a + int'($urandom_range(1, cww - 1))) % cww;
        dat = d; syn = '0; corr = 1'b0; uncorr = 1'b0;
        if (nf == 1) begin
            cw[a] = ~cw[a];
            syn   = a;
            corr  = 1'b1;
        end else if (nf == 2) begin
            cw[a]  = ~cw[a];
            cw[b]  = ~cw[b];
            syn    = a ^ b;
            uncorr = 1'b1;
            dat    = ext(dw, cww, cw);
        end
    endtask

    // Send one codeword through dut_a..c and wait for it to emerge (out_ready high).
    task automatic send4(input logic [7:0] w);
        cw4 = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    logic [31:0] cwd, dd, sd, cwe, de, se;
    logic        cd, ud, ce, ue;
    int          exp_ca, exp_ua, exp_cc, idx, got, seen;
    logic [7:0]  bw[4];
    logic [3:0]  bd[4];
    logic [2:0]  bs[4];

    initial begin
        tbl[0] = '{8'hAA, 4'hB, 4'hB, 3'd0, 1'b0, 1'b0};
        tbl[1] = '{8'h8A, 4'hB, 4'h9, 3'd5, 1'b1, 1'b0};
        tbl[2] = '{8'hAB, 4'hB, 4'hB, 3'd0, 1'b1, 1'b0};
        tbl[3] = '{8'hEE, 4'hF, 4'hF, 3'd4, 1'b0, 1'b1};
        tbl[4] = '{8'h00, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 4'hF, 4'hF, 3'd0, 1'b0, 1'b0};
        tbl[6] = '{8'hF7, 4'hF, 4'hE, 3'd3, 1'b1, 1'b0};
        tbl[7] = '{8'h02, 4'h0, 4'h0, 3'd1, 1'b1, 1'b0};
        tbl[8] = '{8'h28, 4'h3, 4'h3, 3'd6, 1'b0, 1'b1};
        tbl[9] = '{8'h2A, 4'hB, 4'h3, 3'd7, 1'b1, 1'b0};
        bw = '{8'hAA, 8'h8A, 8'hFF, 8'h02};
        bd = '{4'hB, 4'hB, 4'hF, 4'h0};
        bs = '{3'd0, 3'd5, 3'd0, 3'd1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
        cw4 = '0; cw11 = '0; cw26 = '0;
        repeat (2) @(negedge clk);
        check("reset out_valid", ov_a, 0);
        check("reset in_ready", ir_a, 1);
        check("reset out_data", od_a, 0);
        check("reset syndrome", os_a, 0);
        check("reset err_corr", oc_a, 0);
        check("reset err_uncorr", ou_a, 0);
        check("reset corr_count", cc_a, 0);
        check("reset uncorr_count", uc_a, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven vectors, one word in flight at a time.
        exp_ca = 0; exp_ua = 0; exp_cc = 0;
        for (int i = 0; i < 10; i++) begin
            gen(11, 16, cwd, dd, sd, cd, ud);
            gen(26, 32, cwe, de, se, ce, ue);
            cw4 = tbl[i].cw; cw11 = cwd[15:0]; cw26 = cwe; in_valid = 1'b1;
            check($sformatf("vec%0d in_ready", i), ir_a, 1);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("vec%0d early valid", i), ov_a, 0);
            @(negedge clk);
            check($sformatf("vec%0d out_valid", i), ov_a, 1);
            check($sformatf("vec%0d data", i), od_a, tbl[i].dc);
            check($sformatf("vec%0d syndrome", i), os_a, tbl[i].syn);
            check($sformatf("vec%0d corr", i), oc_a, tbl[i].corr);
            check($sformatf("vec%0d uncorr", i), ou_a, tbl[i].uncorr);
            check($sformatf("vec%0d raw data", i), od_b, tbl[i].dr);
            check($sformatf("vec%0d raw corr", i), oc_b, tbl[i].corr);
            check($sformatf("vec%0d raw uncorr", i), ou_b, tbl[i].uncorr);
            check($sformatf("w11 #%0d data", i), od_d, dd[10:0]);
            check($sformatf("w11 #%0d syndrome", i), os_d, sd[3:0]);
            check($sformatf("w11 #%0d flags", i), {oc_d, ou_d}, {cd, ud});
            check($sformatf("w26 #%0d data", i), od_e, de[25:0]);
            check($sformatf("w26 #%0d syndrome", i), os_e, se[4:0]);
            check($sformatf("w26 #%0d flags", i), {oc_e, ou_e}, {ce, ue});
            exp_ca += int'(tbl[i].corr);
            exp_ua += int'(tbl[i].uncorr);
            if (tbl[i].corr && exp_cc < 3) exp_cc++;
            @(negedge clk);
            check($sformatf("vec%0d corr_count", i), cc_a, exp_ca);
            check($sformatf("vec%0d uncorr_count", i), uc_a, exp_ua);
            check($sformatf("vec%0d sat corr_count", i), cc_c, exp_cc);
            check($sformatf("vec%0d drained", i), ov_a, 0);
        end

        // Reset with both stages full: words are discarded, counters cleared.
        out_ready = 1'b0;
        cw4 = 8'h8A; in_valid = 1'b1;
        @(negedge clk);
        cw4 = 8'hEE;
        @(negedge clk);
        in_valid = 1'b0;
        check("full out_valid", ov_a, 1);
        check("full in_ready", ir_a, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midreset out_valid", ov_a, 0);
        check("midreset in_ready", ir_a, 1);
        check("midreset out_data", od_a, 0);
        check("midreset corr_count", cc_a, 0);
        check("midreset uncorr_count", uc_a, 0);
        rst = 1'b0; out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ov_a) seen++;
        end
        check("flushed words emitted", seen, 0);

        // Backpressure: four words offered while out_ready is low for five cycles.
        out_ready = 1'b0; idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 4);
            if (idx < 4) cw4 = bw[idx];
            if (in_valid && ir_a) idx++;
            @(negedge clk);
            if (c >= 1) begin
                check($sformatf("hold%0d out_valid", c), ov_a, 1);
                check($sformatf("hold%0d data", c), od_a, bd[0]);
                check($sformatf("hold%0d syndrome", c), os_a, bs[0]);
            end
        end
        check("accepted under stall", idx, 2);
        check("stalled in_ready", ir_a, 0);
        out_ready = 1'b1;
        #1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            in_valid = (idx < 4);
            if (idx < 4) cw4 = bw[idx];
            if (in_valid && ir_a) idx++;
            if (ov_a) begin
                check($sformatf("drain%0d data", got), od_a, bd[got]);
                check($sformatf("drain%0d syndrome", got), os_a, bs[got]);
                got++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("drained word count", got, 4);
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ov_a) seen++;
        end
        check("no duplicate words", seen, 0);

        // Counter saturation and clear priority.
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        check("cleared corr_count", cc_a, 0);
        check("cleared sat count", cc_c, 0);
        for (int i = 0; i < 5; i++) send4(8'h8A);
        check("five corr_count", cc_a, 5);
        check("saturated corr_count", cc_c, 3);
        cw4 = 8'h8A; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("clear-race out_corr", oc_a, 1);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        check("clear beats incr", cc_a, 0);
        check("clear beats incr sat", cc_c, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
